ofifo_sync: RTL and testbench
=============================

Name: ofifo_sync

Overview:
- Output collection stage that sits directly downstream of the MAC row array.
- Captures per-column partial sums from the bottom row's out_s/valid bus into independent per-column FIFOs.
- Presents them to the SRAM writeback path as aligned rows: one word per column, popped together.
- Absorbs the diagonal skew of column valids, so columns arrive on different cycles but leave as one row.

Parameters:
- col, 8, number of columns / independent FIFOs.
- psum_bw, 16, width of each partial-sum word.
- depth, 64, entries per column FIFO; power of 2, at least 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; state clears on a rising edge while reset==0.
- in  input  col*psum_bw  column data; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
- wr  input  col  per-column write strobe (driven by MAC array valid[c]).
- rd  input  1  row pop request.
- out  output  col*psum_bw  head word of each column, same packing as in.
- o_valid  output  1  every column holds at least one entry.
- o_ready  output  1  every column has at least one free entry.
- o_full  output  1  at least one column is full.
- o_overflow  output  1  sticky: a write was dropped.
- o_count  output  log2(depth)+1  entry count of column 0 (debug).

Behaviour:
- Storage: per column, a depth x psum_bw array, plus wr_ptr and rd_ptr, each log2(depth)+1 bits wide (extra wrap bit).
  - empty_c = (wr_ptr==rd_ptr).
  - full_c = low bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*depth; array index uses the low log2(depth) bits.
- Reset (reset==0 at edge): all pointers 0, o_overflow 0.
  - Resulting outputs: o_valid=0, o_ready=1, o_full=0, o_count=0.
  - out is combinational from the array head and is don't-care while o_valid=0; the bench must not check it then.
  - Array contents are not cleared.
  - Reset overrides any wr/rd in the same cycle.
  - Mid-operation reset discards all stored data.
- Pop: pop = rd & o_valid.
  - On pop, every column's rd_ptr increments by 1 at the edge.
  - rd while o_valid=0 is ignored: no pointer change, no error.
- Write, column c: accept_c = wr[c] & (!full_c | pop).
  - On accept, in[c] is written at wr_ptr_c and wr_ptr_c increments.
  - Write to a full column in a cycle with no pop: dropped, wr_ptr unchanged, o_overflow set to 1 and held until reset.
  - Simultaneous write and pop on a full column: both take effect; count stays depth.
  - Simultaneous write and pop on a column holding 1 entry: pop removes the old head, the new word becomes head next cycle, count stays 1.
- Output timing:
  - First-word-fall-through. A word written at edge N is visible on out, and contributes to o_valid, after edge N (zero added latency).
  - o_valid, o_ready, o_full and o_count are combinational from pointer state only; no combinational path from wr or rd.
- o_count = wr_ptr_0 - rd_ptr_0, modulo 2*depth.
- Columns are fully independent except for the shared pop. Skewed arrivals (column c valid c cycles after column 0) naturally align row-wise.

Test Plan:
- Reset, then idle → o_valid=0, o_ready=1, o_full=0, o_overflow=0, o_count=0. Pulse rd → no state change.
- Skewed fill: wr[c] pulsed at cycle c with in[c]=16'h0100+c, col=8. Expected:
  - o_valid=0 through cycle 7, and o_valid=1 the cycle after the column 7 write.
  - out = {16'h0107,...,16'h0100}.
  - rd=1 for one cycle → o_valid=0 and o_count=0.
- Stream: write rows k=0..9 (all wr=8'hFF, every word = k). Then hold rd=1 → out shows rows 0..9 in order on consecutive cycles, and o_valid drops after row 9.
- Full/overflow, depth=64: write column 0 only, 65 times.
  - After 64 writes: o_full=1, o_ready=0, o_count=64.
  - The 65th write is dropped and o_overflow=1.
  - Remaining columns empty → o_valid=0.
- Full with concurrent pop: fill all columns to 64. Then one cycle with wr=8'hFF, in=16'hBEEF in all columns, rd=1. Expected:
  - o_count stays 64 and o_overflow stays 0.
  - After 63 further pops, head=16'hBEEF.
- Wrap and reset: push/pop 200 rows, checking data order across pointer wrap. Then assert reset=0 for one cycle mid-stream with wr=8'hFF, rd=1 → o_valid=0, o_count=0, o_overflow=0, and the write in that cycle is discarded.

Source files
------------

// File: rtl/ofifo_sync_if.sv
// Handshake bundle between the MAC row array / writeback controller and the
// output collection FIFOs. The master drives column data, strobes and row pops.
interface ofifo_sync_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
);
  localparam int CW = $clog2(depth) + 1;

  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   o_overflow;
  logic [CW-1:0]          o_count;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_ready, o_full, o_overflow, o_count
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_ready, o_full, o_overflow, o_count
  );
endinterface

// File: rtl/ofifo_sync.sv
// Per-column partial-sum FIFOs that absorb the diagonal skew of the MAC array
// and release one aligned row per pop, first-word-fall-through.
module ofifo_sync #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input logic         clk,
  input logic         reset,
  ofifo_sync_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;

  logic [psum_bw-1:0] mem_q [col][depth];
  logic [PW-1:0]      wr_ptr_q [col];
  logic [PW-1:0]      wr_ptr_d [col];
  // Pops are always row-wide, so every column's read pointer is identical.
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [col-1:0]     empty_c, full_c, accept_c;
  logic               valid, pop;

  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int c = 0; c < col; c++) begin
      empty_c[c] = (wr_ptr_q[c] == rd_ptr_q);
      full_c[c]  = (wr_ptr_q[c][AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[c][AW] != rd_ptr_q[AW]);
    end
  end

  assign valid = ~|empty_c;
  assign pop   = bus.rd & valid;

  // A pop in the same cycle frees the slot a write into a full column needs.
  always_comb begin
    accept_c = '0;
    for (int c = 0; c < col; c++) begin
      accept_c[c] = bus.wr[c] & (~full_c[c] | pop);
      wr_ptr_d[c] = accept_c[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
    end
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (|(bus.wr & ~accept_c));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) wr_ptr_q[c] <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) wr_ptr_q[c] <= wr_ptr_d[c];
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not cleared; a write landing during reset is unreachable afterwards.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (accept_c[c]) mem_q[c][wr_ptr_q[c][AW-1:0]] <= bus.in[psum_bw*c +: psum_bw];
    end
  end

  for (genvar g = 0; g < col; g++) begin : g_out
    assign bus.out[psum_bw*g +: psum_bw] = mem_q[g][rd_ptr_q[AW-1:0]];
  end

  assign bus.o_valid    = valid;
  assign bus.o_ready    = ~|full_c;
  assign bus.o_full     = |full_c;
  assign bus.o_overflow = overflow_q;
  assign bus.o_count    = wr_ptr_q[0] - rd_ptr_q;
endmodule

// File: tb/tb_ofifo_sync.sv
// Bench for ofifo_sync: vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_ofifo_sync;
  localparam int COL = 8, BW = 16, DEPTH = 64, PW = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_sync_if #(.col(COL), .psum_bw(BW), .depth(DEPTH)) bus ();
  ofifo_sync #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] mq [COL][$];
  logic          m_ovf = 1'b0;

  typedef struct {
    logic           rst;
    logic [COL-1:0] wr;
    logic           rd;
    logic [BW-1:0]  data;
    logic           v, r, f, o;
    logic [PW-1:0]  cnt;
    logic [BW-1:0]  head;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [COL*BW-1:0] rep(input logic [BW-1:0] w);
    return {COL{w}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic [COL-1:0] wr_v,
                            input logic [COL*BW-1:0] in_v, input logic rd_v);
    bit all_ne = 1'b1;
    bit do_pop;
    if (!rst_v) begin
      for (int c = 0; c < COL; c++) mq[c].delete();
      m_ovf = 1'b0;
      return;
    end
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) all_ne = 1'b0;
    do_pop = rd_v && all_ne;
    for (int c = 0; c < COL; c++) begin
      bit was_full;
      was_full = (mq[c].size() == DEPTH);
      if (do_pop) void'(mq[c].pop_front());
      if (wr_v[c]) begin
        if (!was_full || do_pop) mq[c].push_back(in_v[BW*c +: BW]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit mv = 1'b1;
    bit mf = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) mv = 1'b0;
      if (mq[c].size() == DEPTH) mf = 1'b1;
    end
    chk({tag, ".valid"}, 128'(bus.o_valid), 128'(mv));
    chk({tag, ".ready"}, 128'(bus.o_ready), 128'(!mf));
    chk({tag, ".full"}, 128'(bus.o_full), 128'(mf));
    chk({tag, ".ovf"}, 128'(bus.o_overflow), 128'(m_ovf));
    chk({tag, ".count"}, 128'(bus.o_count), 128'(mq[0].size()));
    if (mv) begin
      for (int c = 0; c < COL; c++)
        chk($sformatf("%s.out%0d", tag, c), 128'(bus.out[BW*c +: BW]), 128'(mq[c][0]));
    end
  endtask

  task automatic cycle(input string tag, input logic rst_v, input logic [COL-1:0] wr_v,
                       input logic [COL*BW-1:0] in_v, input logic rd_v);
    reset  = rst_v;
    bus.wr = wr_v;
    bus.in = in_v;
    bus.rd = rd_v;
    @(posedge clk);
    #1;
    model_edge(rst_v, wr_v, in_v, rd_v);
    reset  = 1'b1;
    bus.wr = '0;
    bus.rd = 1'b0;
    check_model(tag);
  endtask

  initial begin
    logic [COL*BW-1:0] exp_row;
    logic [COL*BW-1:0] rnd;

    reset  = 1'b0;
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;

    //          rst   wr     rd    data    v     r     f     o     cnt   head
    vecs[0] = '{1'b0, 8'h00, 1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0};
    vecs[2] = '{1'b1, 8'h00, 1'b1, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0};
    vecs[3] = '{1'b1, 8'h01, 1'b0, 16'h5,  1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 16'h0};
    vecs[4] = '{1'b1, 8'hFE, 1'b0, 16'h6,  1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 16'h5};
    vecs[5] = '{1'b1, 8'h00, 1'b1, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0};
    vecs[6] = '{1'b1, 8'hFF, 1'b1, 16'h7,  1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 16'h7};
    vecs[7] = '{1'b1, 8'hFF, 1'b1, 16'h8,  1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 16'h8};
    vecs[8] = '{1'b1, 8'h00, 1'b1, 16'h0,  1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 16'h0};

    for (int i = 0; i < 9; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(t, vecs[i].rst, vecs[i].wr, rep(vecs[i].data), vecs[i].rd);
      chk({t, ".v"}, 128'(bus.o_valid), 128'(vecs[i].v));
      chk({t, ".r"}, 128'(bus.o_ready), 128'(vecs[i].r));
      chk({t, ".f"}, 128'(bus.o_full), 128'(vecs[i].f));
      chk({t, ".o"}, 128'(bus.o_overflow), 128'(vecs[i].o));
      chk({t, ".cnt"}, 128'(bus.o_count), 128'(vecs[i].cnt));
      if (vecs[i].v) chk({t, ".head"}, 128'(bus.out[BW-1:0]), 128'(vecs[i].head));
    end

    // Skewed fill: column c arrives on cycle c
    cycle("skew_rst", 1'b0, 8'h00, '0, 1'b0);
    for (int c = 0; c < COL; c++) begin
      cycle($sformatf("skew%0d", c), 1'b1, 8'(1 << c), rep(16'h0100 + 16'(c)), 1'b0);
      chk($sformatf("skew%0d.valid", c), 128'(bus.o_valid), 128'(c == COL - 1));
    end
    for (int c = 0; c < COL; c++) exp_row[BW*c +: BW] = 16'h0100 + 16'(c);
    chk("skew.row", 128'(bus.out), 128'(exp_row));
    cycle("skew_pop", 1'b1, 8'h00, '0, 1'b1);
    chk("skew_pop.valid", 128'(bus.o_valid), 128'(0));
    chk("skew_pop.count", 128'(bus.o_count), 128'(0));

    // Stream of ten rows drained back-to-back
    for (int k = 0; k < 10; k++) cycle("stream_wr", 1'b1, 8'hFF, rep(16'(k)), 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stream_row%0d", k), 128'(bus.out), 128'(rep(16'(k))));
      cycle("stream_rd", 1'b1, 8'h00, '0, 1'b1);
    end
    chk("stream.empty", 128'(bus.o_valid), 128'(0));

    // Column 0 overflow
    cycle("ovf_rst", 1'b0, 8'h00, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("ovf_fill", 1'b1, 8'h01, rep(16'(i)), 1'b0);
    chk("ovf64.full", 128'(bus.o_full), 128'(1));
    chk("ovf64.ready", 128'(bus.o_ready), 128'(0));
    chk("ovf64.count", 128'(bus.o_count), 128'(64));
    chk("ovf64.ovf", 128'(bus.o_overflow), 128'(0));
    cycle("ovf65", 1'b1, 8'h01, rep(16'hDEAD), 1'b0);
    chk("ovf65.ovf", 128'(bus.o_overflow), 128'(1));
    chk("ovf65.count", 128'(bus.o_count), 128'(64));
    chk("ovf65.valid", 128'(bus.o_valid), 128'(0));

    // Full with concurrent write and pop
    cycle("fp_rst", 1'b0, 8'h00, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("fp_fill", 1'b1, 8'hFF, rep(16'(i)), 1'b0);
    cycle("fp_both", 1'b1, 8'hFF, rep(16'hBEEF), 1'b1);
    chk("fp_both.count", 128'(bus.o_count), 128'(64));
    chk("fp_both.ovf", 128'(bus.o_overflow), 128'(0));
    for (int i = 0; i < DEPTH - 1; i++) cycle("fp_drain", 1'b1, 8'h00, '0, 1'b1);
    chk("fp_head", 128'(bus.out), 128'(rep(16'hBEEF)));

    // Random push/pop across pointer wrap, then mid-stream reset
    cycle("rnd_rst", 1'b0, 8'h00, '0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [COL-1:0] wm;
      for (int c = 0; c < COL; c++) rnd[BW*c +: BW] = 16'($urandom);
      wm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      cycle("rnd", 1'b1, wm, rnd, $urandom_range(0, 3) != 0);
    end
    cycle("mid_rst", 1'b0, 8'hFF, rep(16'hAAAA), 1'b1);
    chk("mid_rst.valid", 128'(bus.o_valid), 128'(0));
    chk("mid_rst.count", 128'(bus.o_count), 128'(0));
    chk("mid_rst.ovf", 128'(bus.o_overflow), 128'(0));
    for (int i = 0; i < 50; i++) begin
      for (int c = 0; c < COL; c++) rnd[BW*c +: BW] = 16'($urandom);
      cycle("post_rst", 1'b1, 8'($urandom), rnd, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
